// File: rtl/hit_scheduler.sv
// Nearest-hit scheduler: streams every triangle of the scene against one ray
// through the p_hit datapath and reports the closest positive-t hit per ray.
module hit_scheduler #(
    parameter int Q_BITS  = 16,
    parameter int NUM_TRI = 16,
    localparam int IDX_W  = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1,
    localparam int CNT_W  = $clog2(NUM_TRI + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    // ray FIFO (show-ahead)
    input  logic [2:0][31:0]        ray_origin,
    input  logic [2:0][31:0]        ray_dir,
    input  logic                    ray_empty,
    output logic                    ray_rd_en,
    // triangle memory (synchronous, 1-cycle read)
    output logic [IDX_W-1:0]        tri_addr,
    input  logic [2:0][31:0]        tri_v0,
    input  logic [2:0][31:0]        tri_normal_1,
    input  logic [2:0][31:0]        tri_normal_2,
    // datapath operand FIFOs
    output logic                    dp_wr_en,
    input  logic                    dp_full,
    output logic [2:0][31:0]        dp_origin,
    output logic [2:0][31:0]        dp_dir,
    output logic [2:0][31:0]        dp_v0,
    output logic [2:0][31:0]        dp_normal_1,
    output logic [2:0][31:0]        dp_normal_2,
    // datapath result FIFO
    input  logic                    dp_res_empty,
    output logic                    dp_res_rd_en,
    input  logic                    dp_hit,
    input  logic signed [31:0]      dp_t,
    // per-ray result FIFO
    input  logic                    res_full,
    output logic                    res_wr_en,
    output logic                    res_hit,
    output logic signed [31:0]      res_t,
    output logic [IDX_W-1:0]        res_tri_id
);

    // Fixed-point vectors pass through untouched; Q_BITS only documents the format.
    if (Q_BITS < 0 || Q_BITS > 31) begin : g_bad_q_bits
        $error("hit_scheduler: Q_BITS must lie in 0..31");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} state_e;

    localparam logic signed [31:0] T_INIT    = 32'sh7FFF_FFFF;
    localparam logic [CNT_W-1:0]   NUM_TRI_C = CNT_W'(NUM_TRI);

    state_e                 state_q, state_d;
    logic [2:0][31:0]       origin_q, origin_d;
    logic [2:0][31:0]       dir_q, dir_d;
    logic [IDX_W-1:0]       tri_idx_q, tri_idx_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [CNT_W-1:0]       received_q, received_d;
    logic                   data_valid_q, data_valid_d;
    logic                   best_hit_q, best_hit_d;
    logic signed [31:0]     best_t_q, best_t_d;
    logic [IDX_W-1:0]       best_id_q, best_id_d;

    logic issue;
    logic pop;
    logic better;

    // data_valid marks that the synchronous memory already presents tri_idx.
    assign issue  = (state_q == ISSUE) && data_valid_q && !dp_full && (issued_q < NUM_TRI_C);
    assign pop    = ((state_q == ISSUE) || (state_q == DRAIN)) && !dp_res_empty;
    assign better = dp_hit && (dp_t > 0) && (dp_t < best_t_q);

    // Prefetch the next triangle on an issue so back-to-back issues never bubble.
    assign tri_addr = issue ? tri_idx_q + IDX_W'(1) : tri_idx_q;

    assign dp_wr_en     = issue;
    assign dp_res_rd_en = pop;
    assign dp_origin    = origin_q;
    assign dp_dir       = dir_q;
    assign dp_v0        = tri_v0;
    assign dp_normal_1  = tri_normal_1;
    assign dp_normal_2  = tri_normal_2;

    assign res_hit    = (state_q == EMIT) ? best_hit_q : 1'b0;
    assign res_t      = (state_q == EMIT) ? best_t_q   : '0;
    assign res_tri_id = (state_q == EMIT) ? best_id_q  : '0;

    always_comb begin
        // NOTE: every output and next-state gets a default first so no latch is inferred.
        state_d      = state_q;
        origin_d     = origin_q;
        dir_d        = dir_q;
        tri_idx_d    = tri_idx_q;
        issued_d     = issued_q;
        received_d   = received_q;
        data_valid_d = data_valid_q;
        best_hit_d   = best_hit_q;
        best_t_d     = best_t_q;
        best_id_d    = best_id_q;
        ray_rd_en    = 1'b0;
        res_wr_en    = 1'b0;

        if (issue) begin
            tri_idx_d = tri_idx_q + IDX_W'(1);
            issued_d  = issued_q + CNT_W'(1);
        end

        // Results come back in issue order, so the pop count is the triangle id.
        if (pop) begin
            received_d = received_q + CNT_W'(1);
            if (better) begin
                best_hit_d = 1'b1;
                best_t_d   = dp_t;
                best_id_d  = IDX_W'(received_q);
            end
        end

        unique case (state_q)
            IDLE: begin
                // Qualified with reset so no pop leaks out while the FIFOs are being reset.
                if (!ray_empty && reset) begin
                    ray_rd_en    = 1'b1;
                    origin_d     = ray_origin;
                    dir_d        = ray_dir;
                    tri_idx_d    = '0;
                    issued_d     = '0;
                    received_d   = '0;
                    data_valid_d = 1'b0;
                    best_hit_d   = 1'b0;
                    best_t_d     = T_INIT;
                    best_id_d    = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                data_valid_d = 1'b1;
                if (issue && (issued_q == NUM_TRI_C - CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (received_d == NUM_TRI_C) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (!res_full) begin
                    res_wr_en = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            origin_q     <= '0;
            dir_q        <= '0;
            tri_idx_q    <= '0;
            issued_q     <= '0;
            received_q   <= '0;
            data_valid_q <= 1'b0;
            best_hit_q   <= 1'b0;
            best_t_q     <= T_INIT;
            best_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            origin_q     <= origin_d;
            dir_q        <= dir_d;
            tri_idx_q    <= tri_idx_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            data_valid_q <= data_valid_d;
            best_hit_q   <= best_hit_d;
            best_t_q     <= best_t_d;
            best_id_q    <= best_id_d;
        end
    end

endmodule

// File: tb/tb_hit_scheduler.sv
// Scoreboard bench for hit_scheduler (NUM_TRI=4): models ray FIFO, triangle
// memory and a variable-latency datapath; expected per-ray results are queued.
module tb_hit_scheduler;

    localparam int NT = 4;
    localparam int IW = 2;

    typedef logic [2:0][31:0] vec3_t;
    typedef struct packed {
        vec3_t               o;
        vec3_t               d;
        logic [NT-1:0]       hit;
        logic [NT-1:0][31:0] t;
    } ray_t;
    typedef struct packed {
        logic          hit;
        logic [31:0]   t;
        logic [IW-1:0] id;
    } best_t;
    typedef struct packed {
        logic        hit;
        logic [31:0] t;
        int          rdy;
    } dpres_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    vec3_t         ray_origin = '0, ray_dir = '0;
    logic          ray_empty = 1'b1;
    logic          ray_rd_en;
    logic [IW-1:0] tri_addr;
    vec3_t         tri_v0 = '0, tri_normal_1 = '0, tri_normal_2 = '0;
    logic          dp_wr_en;
    logic          dp_full = 1'b0;
    vec3_t         dp_origin, dp_dir, dp_v0, dp_normal_1, dp_normal_2;
    logic          dp_res_empty = 1'b1;
    logic          dp_res_rd_en;
    logic          dp_hit = 1'b0;
    logic [31:0]   dp_t = '0;
    logic          res_full = 1'b0;
    logic          res_wr_en;
    logic          res_hit;
    logic [31:0]   res_t;
    logic [IW-1:0] res_tri_id;

    hit_scheduler #(.Q_BITS(16), .NUM_TRI(NT)) dut (
        .clock        (clock),
        .reset        (reset),
        .ray_origin   (ray_origin),
        .ray_dir      (ray_dir),
        .ray_empty    (ray_empty),
        .ray_rd_en    (ray_rd_en),
        .tri_addr     (tri_addr),
        .tri_v0       (tri_v0),
        .tri_normal_1 (tri_normal_1),
        .tri_normal_2 (tri_normal_2),
        .dp_wr_en     (dp_wr_en),
        .dp_full      (dp_full),
        .dp_origin    (dp_origin),
        .dp_dir       (dp_dir),
        .dp_v0        (dp_v0),
        .dp_normal_1  (dp_normal_1),
        .dp_normal_2  (dp_normal_2),
        .dp_res_empty (dp_res_empty),
        .dp_res_rd_en (dp_res_rd_en),
        .dp_hit       (dp_hit),
        .dp_t         (dp_t),
        .res_full     (res_full),
        .res_wr_en    (res_wr_en),
        .res_hit      (res_hit),
        .res_t        (res_t),
        .res_tri_id   (res_tri_id)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    vec3_t  mem_v0 [NT];
    vec3_t  mem_n1 [NT];
    vec3_t  mem_n2 [NT];
    ray_t   ray_q  [$];
    best_t  exp_q  [$];
    dpres_t pend_q [$];

    ray_t          cur;
    bit            busy = 0;
    int            issues = 0, pops = 0, cyc = 0, last_res_cyc = -100, last_rdy = 0;
    int            full_at = -1, full_len = 0, full_cnt = 0;
    bit            hold_res = 0;
    int            hold_cnt = 0;
    int            reset_at = -1;
    bit            s_ray, s_rd;
    logic [IW-1:0] s_addr;

    function automatic best_t golden(input ray_t r);
        best_t b;
        b.hit = 1'b0;
        b.t   = 32'h7FFF_FFFF;
        b.id  = '0;
        for (int i = 0; i < NT; i++) begin
            if (r.hit[i] && $signed(r.t[i]) > 0 && $signed(r.t[i]) < $signed(b.t)) begin
                b.hit = 1'b1;
                b.t   = r.t[i];
                b.id  = IW'(i);
            end
        end
        return b;
    endfunction

    function automatic ray_t make_ray();
        ray_t r;
        for (int j = 0; j < 3; j++) begin
            r.o[j] = $urandom;
            r.d[j] = $urandom;
        end
        for (int i = 0; i < NT; i++) begin
            r.hit[i] = ($urandom_range(0, 3) != 0);
            r.t[i]   = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 4)) << 16);
        end
        return r;
    endfunction

    task automatic push_ray(input ray_t r, input best_t e);
        ray_q.push_back(r);
        exp_q.push_back(e);
    endtask

    // One clock: sample and check DUT outputs at the falling edge, then update
    // the environment models just after the rising edge.
    task automatic tick();
        best_t e;
        dpres_t p;
        @(negedge clock);
        s_ray  = 0;
        s_rd   = 0;
        s_addr = tri_addr;
        if (reset) begin
            if (hold_res && res_full && busy && pops == NT && exp_q.size() != 0) begin
                check("hold_wr_en", res_wr_en, 0);
                check("hold_res", {res_hit, res_t, res_tri_id}, exp_q[0]);
                check("hold_ray_rd", ray_rd_en, 0);
                hold_cnt++;
            end
            if (ray_rd_en) begin
                check("ray_pop_idle", busy, 0);
                s_ray = 1;
            end
            if (dp_wr_en) begin
                check("issue_in_range", issues < NT, 1);
                check("issue_not_full", dp_full, 0);
                check("op_origin", dp_origin, cur.o);
                check("op_dir", dp_dir, cur.d);
                check("op_v0", dp_v0, mem_v0[issues % NT]);
                check("op_n1", dp_normal_1, mem_n1[issues % NT]);
                check("op_n2", dp_normal_2, mem_n2[issues % NT]);
                if (issues == 0) check("issue_gap", (cyc - last_res_cyc) >= 2, 1);
                p.hit = cur.hit[issues % NT];
                p.t   = cur.t[issues % NT];
                p.rdy = cyc + int'($urandom_range(1, 4));
                if (p.rdy < last_rdy) p.rdy = last_rdy;
                last_rdy = p.rdy;
                pend_q.push_back(p);
                issues++;
            end
            if (dp_res_rd_en) begin
                check("pop_not_empty", dp_res_empty, 0);
                s_rd = 1;
                pops++;
            end
            if (res_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", res_wr_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_hit", res_hit, e.hit);
                    check("res_t", res_t, e.t);
                    check("res_id", res_tri_id, e.id);
                    check("res_issues", issues, NT);
                    check("res_pops", pops, NT);
                end
                check("res_not_full", res_full, 0);
                busy = 0;
                last_res_cyc = cyc;
            end
        end

        @(posedge clock);
        #1;
        cyc++;
        if (s_ray && ray_q.size() != 0) begin
            cur    = ray_q.pop_front();
            busy   = 1;
            issues = 0;
            pops   = 0;
        end
        if (s_rd && pend_q.size() != 0) void'(pend_q.pop_front());
        dp_full = 1'b0;
        if (busy && issues == full_at && full_cnt < full_len) begin
            dp_full = 1'b1;
            full_cnt++;
        end
        res_full = hold_res && (hold_cnt < 5);
        if (reset_at >= 0 && busy && issues == reset_at) begin
            reset = 1'b0;
            #1;
            check("rst_mid_strobes", {ray_rd_en, dp_wr_en, dp_res_rd_en, res_wr_en}, 4'b0);
            check("rst_mid_res", {res_hit, res_t, res_tri_id}, '0);
            ray_q.delete();
            pend_q.delete();
            exp_q.delete();
            busy     = 0;
            reset_at = -1;
        end
        ray_empty = (ray_q.size() == 0);
        if (ray_q.size() != 0) begin
            ray_origin = ray_q[0].o;
            ray_dir    = ray_q[0].d;
        end
        tri_v0       = mem_v0[s_addr];
        tri_normal_1 = mem_n1[s_addr];
        tri_normal_2 = mem_n2[s_addr];
        if (pend_q.size() != 0 && pend_q[0].rdy <= cyc) begin
            dp_res_empty = 1'b0;
            dp_hit       = pend_q[0].hit;
            dp_t         = pend_q[0].t;
        end else begin
            dp_res_empty = 1'b1;
            dp_hit       = 1'b0;
            dp_t         = '0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", exp_q.size(), 0);
    endtask

    initial begin
        ray_t  r;
        best_t e;
        for (int k = 0; k < NT; k++) begin
            for (int j = 0; j < 3; j++) begin
                mem_v0[k][j] = 32'h1000_0000 | (32'(k) << 8) | 32'(j);
                mem_n1[k][j] = 32'h2000_0000 | (32'(k) << 8) | 32'(j);
                mem_n2[k][j] = 32'h3000_0000 | (32'(k) << 8) | 32'(j);
            end
        end

        // Nearest hit with a tie: ids 1 and 3 share t=1.0, lower id wins.
        r = make_ray();
        r.hit  = 4'b1111;
        r.t[0] = 32'h0003_0000;
        r.t[1] = 32'h0001_0000;
        r.t[2] = 32'h0002_0000;
        r.t[3] = 32'h0001_0000;
        e.hit = 1'b1; e.t = 32'h0001_0000; e.id = 2'd1;
        push_ray(r, e);

        // Ray is waiting while reset is held: nothing may move.
        repeat (2) tick();
        check("rst_strobes", {ray_rd_en, dp_wr_en, dp_res_rd_en, res_wr_en}, 4'b0);
        check("rst_res", {res_hit, res_t, res_tri_id}, '0);
        check("rst_addr", tri_addr, 0);
        reset = 1'b1;
        wait_done(500);

        // Misses, t=0 and negative t never count as a hit.
        r = make_ray();
        r.hit  = 4'b0110;
        r.t[0] = 32'h0000_0100;
        r.t[1] = 32'h0000_0000;
        r.t[2] = 32'hFFFF_0000;
        r.t[3] = 32'h0000_5000;
        e.hit = 1'b0; e.t = 32'h7FFF_FFFF; e.id = 2'd0;
        push_ray(r, e);
        wait_done(500);

        // Operand FIFO full for 3 cycles after the second issue.
        full_at = 2; full_len = 3; full_cnt = 0;
        r = make_ray();
        push_ray(r, golden(r));
        wait_done(500);
        full_at = -1;

        // Output FIFO full for 5 cycles in EMIT with another ray already queued.
        hold_res = 1; hold_cnt = 0;
        r = make_ray();
        r.hit  = 4'b1010;
        r.t[1] = 32'h0004_0000;
        r.t[3] = 32'h0002_0000;
        e.hit = 1'b1; e.t = 32'h0002_0000; e.id = 2'd3;
        push_ray(r, e);
        r = make_ray();
        push_ray(r, golden(r));
        wait_done(800);
        hold_res = 0;

        // Three rays back to back.
        for (int n = 0; n < 3; n++) begin
            r = make_ray();
            push_ray(r, golden(r));
        end
        wait_done(1000);

        // Reset after two issues: partial ray dropped, next ray starts clean.
        reset_at = 2;
        r = make_ray();
        push_ray(r, golden(r));
        for (int i = 0; i < 200 && reset; i++) tick();
        check("reset_fired", reset, 0);
        repeat (3) tick();
        reset = 1'b1;
        r = make_ray();
        r.hit  = 4'b1101;
        r.t[0] = 32'h0005_0000;
        r.t[2] = 32'h0000_8000;
        r.t[3] = 32'h0000_8000;
        e.hit = 1'b1; e.t = 32'h0000_8000; e.id = 2'd2;
        push_ray(r, e);
        wait_done(500);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hit_scheduler.md
HIT_SCHEDULER -- requirements
Module: hit_scheduler

Interface
REQ-001 Parameter Q_BITS, 16, fractional bits of all signed 32-bit fixed-point values (passed through, no arithmetic scaling).
REQ-002 Parameter NUM_TRI, 16, triangles tested per ray (>=1); IDX_W = clog2(NUM_TRI), CNT_W = clog2(NUM_TRI+1).
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 ray_origin[2:0], ray_dir[2:0]  in  3x32 signed  head of show-ahead ray FIFO, valid while !ray_empty.
REQ-006 ray_empty  in  1 / ray_rd_en  out  1  ray FIFO empty flag / pop strobe.
REQ-007 tri_addr  out  IDX_W  triangle memory address; memory is synchronous, 1-cycle read.
REQ-008 tri_v0[2:0], tri_normal_1[2:0], tri_normal_2[2:0]  in  3x32 signed each  triangle memory read data.
REQ-009 dp_wr_en  out  1 / dp_full  in  1  write strobe / full flag of p_hit datapath input FIFOs.
REQ-010 dp_origin[2:0], dp_dir[2:0], dp_v0[2:0], dp_normal_1[2:0], dp_normal_2[2:0]  out  3x32 signed each  datapath operands.
REQ-011 dp_res_empty  in  1 / dp_res_rd_en  out  1  datapath result FIFO empty / pop.
REQ-012 dp_hit  in  1, dp_t  in  32 signed  datapath result: hit flag, ray parameter t.
REQ-013 res_full  in  1 / res_wr_en  out  1  output FIFO full / write strobe.
REQ-014 res_hit  out  1, res_t  out  32 signed, res_tri_id  out  IDX_W  nearest-hit result per ray.

Function
REQ-015 States SHALL be IDLE, ISSUE, DRAIN, EMIT.
REQ-016 IDLE: when !ray_empty, assert ray_rd_en one cycle, latch origin/dir, clear tri_idx, issued count, received count, best record; -> ISSUE.
REQ-017 tri_addr SHALL be combinational: tri_idx+1 in an issue cycle, else tri_idx; thus tri_* inputs in cycle k hold triangle tri_idx.
REQ-018 ISSUE: dp_wr_en = data_valid && !dp_full && issued < NUM_TRI; data_valid is clear in the first ISSUE cycle, set thereafter.
REQ-019 Each issue SHALL drive latched origin/dir plus current tri_* on dp_* and increment tri_idx and issued; sustained rate 1 triangle/cycle.
REQ-020 ISSUE -> DRAIN in the cycle issued reaches NUM_TRI; dp_full stalls issue without losing or repeating a triangle.
REQ-021 In ISSUE and DRAIN, dp_res_rd_en = !dp_res_empty; it SHALL be 0 in IDLE and EMIT.
REQ-022 Results return in issue order; the received count SHALL identify the triangle id of each popped result.
REQ-023 A popped result SHALL replace the best record iff dp_hit && dp_t > 0 && dp_t < best_t (signed); equal t keeps the earlier (lower) id.
REQ-024 Best record initial value: hit=0, t=0x7FFFFFFF, id=0.
REQ-025 Issue and result pop in the same cycle SHALL both take effect; outstanding = issued - received never exceeds NUM_TRI.
REQ-026 DRAIN -> EMIT when received == NUM_TRI.
REQ-027 EMIT: drive best record on res_*; assert res_wr_en for exactly one cycle when !res_full, then -> IDLE; hold while res_full.
REQ-028 No ray pop SHALL occur outside IDLE; next ray's first issue no earlier than 2 cycles after the prior res_wr_en.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, all counters and tri_idx to 0, best record to REQ-024 value, all strobes (ray_rd_en, dp_wr_en, dp_res_rd_en, res_wr_en) to 0, res_* to 0.
REQ-030 Reset mid-ray SHALL discard the partial ray without emitting a result; the datapath and FIFOs are reset by the same signal.
REQ-031 Operation resumes on the first rising clock after reset deasserts.

Verification
REQ-032 NUM_TRI=4, one ray, results t={0x30000,0x10000,0x20000,0x10000} all hit -> one res write: hit=1, t=0x10000, id=1.
REQ-033 All four results dp_hit=0, or hit with t=0 or t=0xFFFF0000 -> res_hit=0, res_t=0x7FFFFFFF, res_tri_id=0.
REQ-034 dp_full held high for 3 cycles mid-ISSUE -> exactly 4 dp_wr_en pulses, operands for tri ids 0,1,2,3 in order, none duplicated.
REQ-035 res_full high for 5 cycles in EMIT -> res_wr_en stays 0, res_* stable, single write after release; ray_rd_en stays 0 meanwhile.
REQ-036 Three rays back-to-back, no stalls -> 12 issues, 3 results in ray order, each ray's best matching golden model.
REQ-037 reset asserted after 2 of 4 issues -> all strobes 0 immediately, no result written; next ray after release processed correctly from id 0.
